// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable up/down counter.
package prog_counter_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle of the programmable counter; master drives controls, slave is the counter.
interface prog_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en_i;
    logic             up_dn_i;
    logic             mode_i;
    logic [WIDTH-1:0] max_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] count_o;
    logic             tc_o;
    logic             wrap_o;
    logic             done_o;

    modport master (
        output en_i, up_dn_i, mode_i, max_i, load_i, load_val_i,
        input  count_o, tc_o, wrap_o, done_o
    );

    modport slave (
        input  en_i, up_dn_i, mode_i, max_i, load_i, load_val_i,
        output count_o, tc_o, wrap_o, done_o
    );

endinterface

// File: rtl/prog_counter.sv
// Programmable-range up/down counter with WRAP and ONESHOT modes, load with clamp to max_i.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input logic            clk_i,
    input logic            rst_i,
    prog_counter_if.slave  bus
);

    state_e           state_r;
    state_e           nxt_state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] nxt_count_s;
    logic             wrap_r;
    logic             nxt_wrap_s;
    logic             done_r;

    // Next-state, next-count and wrap pulse; DONE freezes everything except load.
    always_comb begin
        nxt_state_s = state_r;
        nxt_count_s = count_r;
        nxt_wrap_s  = 1'b0;
        if (bus.load_i) begin
            nxt_count_s = (bus.load_val_i > bus.max_i) ? bus.max_i : bus.load_val_i;
            nxt_state_s = ST_RUN;
        end else if (bus.en_i && (state_r == ST_RUN)) begin
            if (bus.up_dn_i) begin
                // Terminal uses >= so a count above a lowered max_i still terminates.
                if (count_r >= bus.max_i) begin
                    if (bus.mode_i == MODE_WRAP) begin
                        nxt_count_s = {WIDTH{1'b0}};
                        nxt_wrap_s  = 1'b1;
                    end else begin
                        nxt_count_s = bus.max_i;
                        nxt_state_s = ST_DONE;
                    end
                end else begin
                    nxt_count_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                if (count_r == {WIDTH{1'b0}}) begin
                    if (bus.mode_i == MODE_WRAP) begin
                        nxt_count_s = bus.max_i;
                        nxt_wrap_s  = 1'b1;
                    end else begin
                        nxt_count_s = {WIDTH{1'b0}};
                        nxt_state_s = ST_DONE;
                    end
                end else begin
                    nxt_count_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            nxt_state_s = state_r;
        end
    end

    // State, count and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            count_r <= WIDTH'(RESET_VAL);
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            count_r <= nxt_count_s;
            wrap_r  <= nxt_wrap_s;
            done_r  <= (nxt_state_s == ST_DONE);
        end
    end

    assign bus.count_o = count_r;
    assign bus.wrap_o  = wrap_r;
    assign bus.done_o  = done_r;
    assign bus.tc_o    = bus.up_dn_i ? (count_r >= bus.max_i) : (count_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios with literal expectations plus randomized run vs a behavioural model.
module tb_prog_counter;

    localparam int WIDTH = 4;
    localparam int RESET_VAL = 0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   check_en;

    // behavioural model state
    int m_cnt;
    bit m_wrap;
    bit m_done;

    prog_counter_if #(.WIDTH(WIDTH)) bus ();

    prog_counter #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each edge applies the priority reset > load > enabled step, DONE freezes stepping.
    always @(posedge clk) begin
        int mx;
        mx = int'(bus.max_i);
        m_wrap = 1'b0;
        if (rst) begin
            m_cnt  = RESET_VAL;
            m_done = 1'b0;
        end else if (bus.load_i) begin
            m_cnt  = (int'(bus.load_val_i) > mx) ? mx : int'(bus.load_val_i);
            m_done = 1'b0;
        end else if (bus.en_i && !m_done) begin
            if (bus.up_dn_i) begin
                if (m_cnt < mx) m_cnt = m_cnt + 1;
                else if (bus.mode_i == 1'b0) begin m_cnt = 0; m_wrap = 1'b1; end
                else begin m_cnt = mx; m_done = 1'b1; end
            end else begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else if (bus.mode_i == 1'b0) begin m_cnt = mx; m_wrap = 1'b1; end
                else m_done = 1'b1;
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (check_en) begin
            chk("count", int'(bus.count_o), m_cnt);
            chk("wrap", int'(bus.wrap_o), int'(m_wrap));
            chk("done", int'(bus.done_o), int'(m_done));
            chk("tc", int'(bus.tc_o),
                bus.up_dn_i ? int'(m_cnt >= int'(bus.max_i)) : int'(m_cnt == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input bit en, input bit up, input bit mode, input int mx);
        bus.en_i    = en;
        bus.up_dn_i = up;
        bus.mode_i  = mode;
        bus.max_i   = 4'(mx);
    endtask

    task automatic do_load(input int v);
        bus.load_i     = 1'b1;
        bus.load_val_i = 4'(v);
        tick();
        bus.load_i     = 1'b0;
    endtask

    initial begin
        int exp_a[4];
        int exp_w[4];
        int exp_c[5];
        int exp_d[5];
        n_checks = 0;
        n_errors = 0;
        check_en = 1'b0;
        m_cnt = 0; m_wrap = 1'b0; m_done = 1'b0;
        rst = 1'b1;
        bus.load_i = 1'b0;
        bus.load_val_i = 4'd9;
        set_ctl(1'b1, 1'b1, 1'b1, 15);
        tick();
        check_en = 1'b1;
        chk("reset_count", int'(bus.count_o), 0);
        chk("reset_wrap", int'(bus.wrap_o), 0);
        chk("reset_done", int'(bus.done_o), 0);

        // Up wrap through full range
        rst = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b0, 15);
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("up_wrap_count", int'(bus.count_o), i % 16);
            chk("up_wrap_pulse", int'(bus.wrap_o), int'(i == 16));
        end

        // Down wrap with max 9 from 2
        set_ctl(1'b0, 1'b0, 1'b0, 9);
        do_load(2);
        chk("load2", int'(bus.count_o), 2);
        bus.en_i = 1'b1;
        exp_a = '{1, 0, 9, 8};
        exp_w = '{0, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("down_wrap_count", int'(bus.count_o), exp_a[i]);
            chk("down_wrap_pulse", int'(bus.wrap_o), exp_w[i]);
        end

        // Oneshot up to 5 from 3
        set_ctl(1'b0, 1'b1, 1'b1, 5);
        do_load(3);
        bus.en_i = 1'b1;
        exp_c = '{4, 5, 5, 5, 5};
        exp_d = '{0, 0, 1, 1, 1};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("oneshot_count", int'(bus.count_o), exp_c[i]);
            chk("oneshot_done", int'(bus.done_o), exp_d[i]);
        end
        // Direction/max changes are ignored while DONE
        set_ctl(1'b1, 1'b0, 1'b0, 2);
        tick();
        chk("done_hold_count", int'(bus.count_o), 5);
        chk("done_hold_done", int'(bus.done_o), 1);
        bus.en_i = 1'b0;
        do_load(1);
        chk("oneshot_reload_count", int'(bus.count_o), 1);
        chk("oneshot_reload_done", int'(bus.done_o), 0);

        // Load clamp and load priority over enable
        set_ctl(1'b1, 1'b1, 1'b0, 7);
        do_load(12);
        chk("clamp", int'(bus.count_o), 7);
        do_load(3);
        chk("load_over_en", int'(bus.count_o), 3);

        // Reset with load while DONE
        set_ctl(1'b0, 1'b1, 1'b1, 3);
        do_load(3);
        bus.en_i = 1'b1;
        tick();
        chk("enter_done", int'(bus.done_o), 1);
        rst = 1'b1;
        bus.load_i = 1'b1;
        bus.load_val_i = 4'd2;
        tick();
        chk("rst_load_count", int'(bus.count_o), 0);
        chk("rst_load_done", int'(bus.done_o), 0);
        chk("rst_load_wrap", int'(bus.wrap_o), 0);
        rst = 1'b0;
        bus.load_i = 1'b0;

        // max 0 continuous wrap
        set_ctl(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("max0_count", int'(bus.count_o), 0);
            chk("max0_wrap", int'(bus.wrap_o), 1);
        end

        // Randomized run checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst            = ($urandom_range(0, 63) == 0);
            bus.load_i     = ($urandom_range(0, 7) == 0);
            bus.load_val_i = 4'($urandom_range(0, 15));
            bus.en_i       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.up_dn_i = ~bus.up_dn_i;
            if ($urandom_range(0, 15) == 0) bus.mode_i = ~bus.mode_i;
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 3);
                bus.max_i = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            end
            tick();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
